// File: rtl/fft_pkg.sv
// Shared FFT constants: transform size, sample width, loader state encoding
// and the address-generation-unit constants.
package fft_pkg;

    localparam int N_LOG2   = 10;
    localparam int N_POINTS = 1 << N_LOG2;
    localparam int DATA_W   = 16;

    localparam logic [1:0] LDR_IDLE     = 2'd0;
    localparam logic [1:0] LDR_LOAD     = 2'd1;
    localparam logic [1:0] LDR_START    = 2'd2;
    localparam logic [1:0] LDR_WAIT_FFT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = LDR_IDLE,
        S_LOAD     = LDR_LOAD,
        S_START    = LDR_START,
        S_WAIT_FFT = LDR_WAIT_FFT
    } loader_state_t;

    // Address generation unit constants.
    localparam int                AGU_ADDR_W     = N_LOG2;
    localparam int                AGU_NUM_STAGES = N_LOG2;
    localparam logic [N_LOG2-1:0] AGU_LAST_ADDR  = N_LOG2'(N_POINTS - 1);
    localparam logic              AGU_BANK_IN    = 1'b0;

endpackage

// File: rtl/bit_rev.sv
// Combinational bit-reversal of an N_LOG2-bit index; shared by the loader
// and the output unloader.
module bit_rev #(
    parameter int N_LOG2 = fft_pkg::N_LOG2
) (
    input  logic [N_LOG2-1:0] idx_i,
    output logic [N_LOG2-1:0] addr_o
);

    always_comb begin
        addr_o = '0;
        for (int b = 0; b < N_LOG2; b++) begin
            addr_o[b] = idx_i[N_LOG2-1-b];
        end
    end

endmodule

// File: rtl/fft_input_loader.sv
// Loads one frame of real samples into FFT bank 0 at bit-reversed addresses,
// strobes the FFT start, and waits for completion before loading again.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N_LOG2 = fft_pkg::N_LOG2,
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic [DATA_W-1:0]   sample_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    output logic                wr_en_o,
    output logic [N_LOG2-1:0]   wr_addr_o,
    output logic [2*DATA_W-1:0] wr_data_o,
    output logic                start_o,
    input  logic                fft_done_i,
    output logic [CNT_W-1:0]    frame_cnt_o,
    output logic [CNT_W-1:0]    drop_cnt_o,
    output logic [1:0]          dbg_state_o
);

    // Handshake: a sample moves on any rising edge where sample_valid_i and
    // sample_ready_o are both high; ready never depends on valid.

    loader_state_t       state_q, state_d;
    logic [N_LOG2-1:0]   idx_q, idx_d;
    logic                wr_en_q, wr_en_d;
    logic [N_LOG2-1:0]   wr_addr_q, wr_addr_d;
    logic [2*DATA_W-1:0] wr_data_q, wr_data_d;
    logic                start_q, start_d;
    logic [CNT_W-1:0]    frame_q, frame_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [N_LOG2-1:0]   rev_addr;
    logic                ready;
    logic                fire;

    bit_rev #(.N_LOG2(N_LOG2)) u_bit_rev (
        .idx_i  (idx_q),
        .addr_o (rev_addr)
    );

    assign ready = (state_q == S_LOAD) && enable_i;
    assign fire  = ready && sample_valid_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        frame_d   = frame_q;
        drop_d    = drop_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (fire) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = rev_addr;
                    wr_data_d = {sample_i, {DATA_W{1'b0}}};
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == {N_LOG2{1'b1}}) state_d = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                frame_d = frame_q + 1'b1;
                state_d = S_WAIT_FFT;
            end
            S_WAIT_FFT: begin
                if (fft_done_i) state_d = enable_i ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Samples offered while blocked; saturates rather than wrapping.
        if (enable_i && sample_valid_i && !ready && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            frame_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            frame_q   <= frame_d;
            drop_q    <= drop_d;
        end
    end

    assign sample_ready_o = ready;
    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign start_o        = start_q;
    assign frame_cnt_o    = frame_q;
    assign drop_cnt_o     = drop_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized scoreboard bench for fft_input_loader, plus a small
// 4-point / 4-bit-counter instance for drop-counter saturation.
module tb_fft_input_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic [15:0] sample_i = '0;
    logic        sample_valid_i = 1'b0;
    logic        fft_done_i = 1'b0;
    logic        sample_ready_o, wr_en_o, start_o;
    logic [9:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic [15:0] frame_cnt_o, drop_cnt_o;
    logic [1:0]  dbg_state_o;

    fft_input_loader dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .sample_i(sample_i),
        .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .start_o(start_o), .fft_done_i(fft_done_i), .frame_cnt_o(frame_cnt_o),
        .drop_cnt_o(drop_cnt_o), .dbg_state_o(dbg_state_o)
    );

    logic        s_rst = 1'b1;
    logic        s_en = 1'b0;
    logic        s_vld = 1'b0;
    logic [15:0] s_sample = 16'h1234;
    logic        s_ready, s_wr_en, s_start;
    logic [1:0]  s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_frame, s_drop;
    logic [1:0]  s_state;
    int          s_wr_cnt = 0;

    fft_input_loader #(.N_LOG2(2), .DATA_W(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(s_rst), .enable_i(s_en), .sample_i(s_sample),
        .sample_valid_i(s_vld), .sample_ready_o(s_ready), .wr_en_o(s_wr_en),
        .wr_addr_o(s_addr), .wr_data_o(s_data), .start_o(s_start),
        .fft_done_i(1'b0), .frame_cnt_o(s_frame), .drop_cnt_o(s_drop),
        .dbg_state_o(s_state)
    );

    always @(negedge clk) if (s_wr_en) s_wr_cnt++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = loading, 2 = frame handed to FFT.
    int  m_phase = 0;
    int  m_idx = 0;
    int  m_age = 0;
    int  m_drops = 0;
    int  m_frames = 0;
    int  starts_expected = 0;
    int  starts_seen = 0;
    bit  exp_start_next = 1'b0;
    logic [42:0] exp_q[$];   // {last, addr[9:0], data[31:0]}

    function automatic logic [9:0] rev10(input int v);
        int r = 0;
        for (int b = 0; b < 10; b++) r = r * 2 + ((v >> b) & 1);
        return 10'(r);
    endfunction

    task automatic drive(input bit en, input bit vld, input logic [15:0] d, input bit done);
        bit exp_ready;
        @(negedge clk);
        rst = 1'b0; enable_i = en; sample_valid_i = vld; sample_i = d; fft_done_i = done;
        #1;
        exp_ready = (m_phase == 1) && en;
        check("sample_ready", sample_ready_o, exp_ready);
        if (en && vld && !exp_ready && m_drops < 65535) m_drops++;
        case (m_phase)
            0: if (en) m_phase = 1;
            1: if (vld && exp_ready) begin
                   exp_q.push_back({(m_idx == 1023), rev10(m_idx), d, 16'h0000});
                   m_idx++;
                   if (m_idx == 1024) begin
                       m_idx = 0; m_phase = 2; m_age = 0;
                       m_frames++; starts_expected++;
                   end
               end
            default: begin
                if (done && m_age > 0) m_phase = en ? 1 : 0;
                m_age++;
            end
        endcase
    endtask

    task automatic check_counters(input string tag);
        @(posedge clk); #1;
        check({tag, "_frame_cnt"}, frame_cnt_o, 64'(m_frames));
        check({tag, "_drop_cnt"}, drop_cnt_o, 64'(m_drops));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; enable_i = 1'b0; sample_valid_i = 1'b0; fft_done_i = 1'b0;
        @(negedge clk);
        check({tag, "_ready"}, sample_ready_o, 0);
        check({tag, "_wr_en"}, wr_en_o, 0);
        check({tag, "_wr_addr"}, wr_addr_o, 0);
        check({tag, "_wr_data"}, wr_data_o, 0);
        check({tag, "_start"}, start_o, 0);
        check({tag, "_frame_cnt"}, frame_cnt_o, 0);
        check({tag, "_drop_cnt"}, drop_cnt_o, 0);
        m_phase = 0; m_idx = 0; m_drops = 0; m_frames = 0;
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard on every write strobe and checks start_o.
    always @(negedge clk) begin
        if (exp_start_next) begin
            check("start_after_last_write", start_o, 1);
            exp_start_next = 1'b0;
        end else if (start_o) begin
            check("start_unexpected", start_o, 0);
        end
        if (start_o) starts_seen++;
        if (wr_en_o) begin
            if (exp_q.size() == 0) begin
                check("wr_en_unexpected", wr_en_o, 0);
            end else begin
                logic [42:0] e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr_o, e[41:32]);
                check("wr_data", wr_data_o, e[31:0]);
                if (e[42]) exp_start_next = 1'b1;
            end
        end
    end

    initial begin
        int guard;
        bit paused;

        do_reset("reset");

        // Frame 1: ramp 0..1023 back-to-back.
        drive(1, 0, 16'h0, 0);
        for (int i = 0; i < 1024; i++) drive(1, 1, 16'(i), 0);
        repeat (3) drive(1, 0, 16'h0, 0);
        check_counters("frame1");

        // Blocked while waiting on the FFT: 20 drops, no writes.
        repeat (20) drive(1, 1, 16'($urandom), 0);
        drive(1, 0, 16'h0, 0);
        check_counters("blocked");

        // Frame 2: random gaps, enable paused for 50 cycles at idx 300.
        drive(1, 0, 16'h0, 1);
        guard = 0; paused = 1'b0;
        while (m_phase == 1 && guard < 5000) begin
            if (m_idx == 300 && !paused) begin
                repeat (50) drive(0, 1, 16'($urandom), 0);
                paused = 1'b1;
            end else begin
                drive(1, ($urandom_range(0, 3) != 0), 16'($urandom), 0);
            end
            guard++;
        end
        check("frame2_within_budget", (guard < 5000), 1);
        repeat (3) drive(1, 0, 16'h0, 0);
        check_counters("frame2");

        // Done with enable low returns to idle; no drops while disabled.
        drive(0, 0, 16'h0, 1);
        repeat (5) drive(0, 1, 16'($urandom), 0);
        check_counters("idle_disabled");

        // Frame 3: 700 samples then reset; stray done pulse during load.
        drive(1, 0, 16'h0, 0);
        guard = 0;
        while (m_idx < 700 && guard < 5000) begin
            drive(1, ($urandom_range(0, 3) != 0), 16'($urandom), (m_idx == 100));
            guard++;
        end
        check("frame3_within_budget", (guard < 5000), 1);
        do_reset("midframe_reset");

        // Frame 4 restarts from idx 0.
        drive(1, 0, 16'h0, 0);
        for (int i = 0; i < 1024; i++) drive(1, 1, 16'($urandom), 0);
        repeat (3) drive(1, 0, 16'h0, 0);
        check_counters("frame4");
        check("scoreboard_drained", exp_q.size(), 0);
        check("start_count", starts_seen, starts_expected);

        // Saturation on the 4-point instance with a 4-bit drop counter.
        @(negedge clk); s_rst = 1'b0; s_en = 1'b1; s_vld = 1'b1;
        repeat (30) @(negedge clk);
        s_vld = 1'b0;
        @(negedge clk);
        check("small_drop_saturated", s_drop, 4'd15);
        check("small_frame_cnt", s_frame, 4'd1);
        check("small_writes", s_wr_cnt, 4);
        check("small_ready_waiting", s_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
